// File: rtl/prga_encrypt.sv
// ARC4 PRGA encryption engine.
// Reads a length-prefixed plaintext from PT memory, runs the keystream
// generator over an already-scrambled S memory, and writes the
// length-prefixed ciphertext to CT memory. Started with the en/rdy handshake.
// Optional feature macro: PRGA_CKSUM_EN adds an 8-bit running XOR of the
// ciphertext bytes written at indices 1..mlen on port cksum.
module prga_encrypt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
`ifdef PRGA_CKSUM_EN
  ,
  output logic [7:0] cksum
`endif
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RDLEN,
    ST_WRLEN,
    ST_RDI,
    ST_CALCJ,
    ST_WRI,
    ST_WRJ,
    ST_RDPAD,
    ST_XOR
  } state_t;

  state_t     r_state;
  logic       r_rdy;
  logic [7:0] r_sAddr;
  logic       r_sWren;
  logic [7:0] r_ptAddr;
  logic [7:0] r_ctAddr;
  logic       r_ctWren;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic [7:0] r_k;
  logic [7:0] r_mlen;
`ifdef PRGA_CKSUM_EN
  logic [7:0] r_cksum;
`endif

  logic [7:0] w_jNext;
  logic [7:0] w_pad;

  assign w_jNext = r_j + s_rddata;
  assign w_pad   = s_rddata ^ pt_rddata;

  // Sequencer: every state lasts one cycle; addresses and write enables are
  // loaded on the edge that enters the state that uses them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rdy    <= 1'b1;
      r_sAddr  <= 8'd0;
      r_sWren  <= 1'b0;
      r_ptAddr <= 8'd0;
      r_ctAddr <= 8'd0;
      r_ctWren <= 1'b0;
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_si     <= 8'd0;
      r_sj     <= 8'd0;
      r_k      <= 8'd0;
      r_mlen   <= 8'd0;
`ifdef PRGA_CKSUM_EN
      r_cksum  <= 8'd0;
`endif
    end else begin
      r_sWren  <= 1'b0;
      r_ctWren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state  <= ST_RDLEN;
            r_rdy    <= 1'b0;
            r_i      <= 8'd0;
            r_j      <= 8'd0;
            r_ptAddr <= 8'd0;
`ifdef PRGA_CKSUM_EN
            r_cksum  <= 8'd0;
`endif
          end
        end
        ST_RDLEN: begin
          r_state  <= ST_WRLEN;
          r_ctAddr <= 8'd0;
          r_ctWren <= 1'b1;
        end
        ST_WRLEN: begin
          r_mlen <= pt_rddata;
          r_k    <= 8'd1;
          if (pt_rddata == 8'd0) begin
            r_state  <= ST_IDLE;
            r_rdy    <= 1'b1;
            r_sAddr  <= 8'd0;
            r_ptAddr <= 8'd0;
            r_ctAddr <= 8'd0;
          end else begin
            r_state <= ST_RDI;
            r_i     <= r_i + 8'd1;
            r_sAddr <= r_i + 8'd1;
          end
        end
        ST_RDI: begin
          r_state <= ST_CALCJ;
        end
        ST_CALCJ: begin
          r_si    <= s_rddata;
          r_j     <= w_jNext;
          r_state <= ST_WRI;
          r_sAddr <= r_i;
          r_sWren <= 1'b1;
        end
        ST_WRI: begin
          r_sj    <= s_rddata;
          r_state <= ST_WRJ;
          r_sAddr <= r_j;
          r_sWren <= 1'b1;
        end
        ST_WRJ: begin
          r_state  <= ST_RDPAD;
          r_sAddr  <= r_si + r_sj;
          r_ptAddr <= r_k;
        end
        ST_RDPAD: begin
          r_state  <= ST_XOR;
          r_ctAddr <= r_k;
          r_ctWren <= 1'b1;
        end
        ST_XOR: begin
`ifdef PRGA_CKSUM_EN
          r_cksum <= r_cksum ^ w_pad;
`endif
          if (r_k == r_mlen) begin
            r_state  <= ST_IDLE;
            r_rdy    <= 1'b1;
            r_sAddr  <= 8'd0;
            r_ptAddr <= 8'd0;
            r_ctAddr <= 8'd0;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= ST_RDI;
            r_i     <= r_i + 8'd1;
            r_sAddr <= r_i + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  // Values that depend on read data arriving in the current cycle must be
  // steered straight from the memory outputs; everything else is registered.
  always_comb begin
    s_addr    = r_sAddr;
    s_wrdata  = 8'd0;
    ct_wrdata = 8'd0;
    case (r_state)
      ST_CALCJ: s_addr    = w_jNext;
      ST_WRI:   s_wrdata  = s_rddata;
      ST_WRJ:   s_wrdata  = r_si;
      ST_WRLEN: ct_wrdata = pt_rddata;
      ST_XOR:   ct_wrdata = w_pad;
      default:  s_wrdata  = 8'd0;
    endcase
  end

  assign rdy     = r_rdy;
  assign s_wren  = r_sWren;
  assign pt_addr = r_ptAddr;
  assign ct_addr = r_ctAddr;
  assign ct_wren = r_ctWren;
`ifdef PRGA_CKSUM_EN
  assign cksum   = r_cksum;
`endif

endmodule

// File: tb/tb_prga_encrypt.sv
// Self-checking bench for prga_encrypt. Models S, PT and CT as synchronous
// 1-cycle-latency memories and predicts every CT write, the busy window and
// the final S contents from a plain ARC4 PRGA loop.
module tb_prga_encrypt;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;
`ifdef PRGA_CKSUM_EN
  logic [7:0] cksum;
`endif

  logic [7:0] sMem  [256];
  logic [7:0] ptMem [256];
  logic [7:0] ctMem [256];
  logic [7:0] sInit [256];
  logic [7:0] ptInit[256];
  logic [7:0] ctInit[256];
  logic       loadReq;

  int checks   = 0;
  int failures = 0;

  // Model state, owned by the compare process.
  wr_t        expQ[$];
  logic [7:0] expS[256];
  logic [7:0] expCk;
  int         busyLeft;
  logic       runDone;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  prga_encrypt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata),
    .ct_addr  (ct_addr),
    .ct_wrdata(ct_wrdata),
    .ct_wren  (ct_wren)
`ifdef PRGA_CKSUM_EN
    ,
    .cksum    (cksum)
`endif
  );

  // The three on-chip RAMs: synchronous read with old-data-on-write, writes
  // commit at the edge; loadReq bulk-loads fresh contents while idle.
  always @(posedge clk) begin
    if (loadReq) begin
      sMem  <= sInit;
      ptMem <= ptInit;
      ctMem <= ctInit;
    end else begin
      if (s_wren)  sMem[s_addr]   <= s_wrdata;
      if (ct_wren) ctMem[ct_addr] <= ct_wrdata;
    end
    s_rddata  <= sMem[s_addr];
    pt_rddata <= ptMem[pt_addr];
  end

  // One comparison: counts it, and reports it when the DUT disagrees.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Plain ARC4 PRGA over a snapshot of S: predicts the CT write sequence,
  // the final S, the checksum and how many cycles the engine stays busy.
  task automatic buildRun();
    logic [7:0] sm[256];
    logic [7:0] ii, jj, tmp, m, padIdx;
    wr_t w;
    for (int n = 0; n < 256; n++) sm[n] = sMem[n];
    m = ptMem[0];
    expQ.delete();
    w.addr = 8'd0;
    w.data = m;
    expQ.push_back(w);
    ii = 8'd0;
    jj = 8'd0;
    expCk = 8'd0;
    for (int k = 1; k <= int'(m); k++) begin
      ii = ii + 8'd1;
      jj = jj + sm[ii];
      tmp = sm[ii];
      sm[ii] = sm[jj];
      sm[jj] = tmp;
      padIdx = sm[ii] + sm[jj];
      w.addr = 8'(k);
      w.data = ptMem[k] ^ sm[padIdx];
      expCk = expCk ^ w.data;
      expQ.push_back(w);
    end
    for (int n = 0; n < 256; n++) expS[n] = sm[n];
    busyLeft = 2 + 6 * int'(m);
  endtask

  // Compare process: advances the model on each rising edge, then checks the
  // DUT outputs against it on the following falling edge.
  initial begin
    wr_t w;
    int  sBad;
    busyLeft = 0;
    runDone  = 1'b0;
    expCk    = 8'd0;
    forever begin
      @(posedge clk);
      runDone = 1'b0;
      if (rst_n !== 1'b1) begin
        busyLeft = 0;
        expQ.delete();
      end else if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) runDone = 1'b1;
      end else if (en === 1'b1) begin
        buildRun();
      end
      @(negedge clk);
      checkOutput("rdy", 64'(rdy), 64'(busyLeft == 0));
      if (busyLeft == 0) begin
        checkOutput("idleOutputs",
                    64'({s_addr, pt_addr, ct_addr, ct_wrdata, s_wrdata, s_wren, ct_wren}), 64'd0);
      end
      if (ct_wren === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL ctExtraWrite actual addr=%0h data=%0h required no write", ct_addr, ct_wrdata);
        end else begin
          w = expQ.pop_front();
          checkOutput("ctAddr", 64'(ct_addr), 64'(w.addr));
          checkOutput("ctData", 64'(ct_wrdata), 64'(w.data));
        end
      end
      if (runDone) begin
        checkOutput("ctMissingWrites", 64'(expQ.size()), 64'd0);
        sBad = 0;
        for (int n = 0; n < 256; n++) if (sMem[n] !== expS[n]) sBad++;
        checkOutput("sFinalMismatches", 64'(sBad), 64'd0);
`ifdef PRGA_CKSUM_EN
        checkOutput("cksumModel", 64'(cksum), 64'(expCk));
`endif
      end
    end
  end

  // Identity S, zero plaintext, sentinel 0xAA in every CT location.
  task automatic setIdentity();
    for (int n = 0; n < 256; n++) begin
      sInit[n]  = 8'(n);
      ptInit[n] = 8'h00;
      ctInit[n] = 8'hAA;
    end
  endtask

  // Loads the memories from the init arrays and then pulses en for one edge;
  // returns on the falling edge just after the start edge.
  task automatic applyStimulus();
    @(negedge clk);
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Counts cycles until rdy returns, and how many of them wrote S.
  task automatic waitRdy(output int cyc, output int swr);
    cyc = 0;
    swr = 0;
    while (rdy !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (s_wren === 1'b1) swr++;
    end
    checkOutput("rdyReturned", 64'(rdy), 64'd1);
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    int cyc, swr, n;
    rst_n   = 1'b0;
    en      = 1'b0;
    loadReq = 1'b0;
    setIdentity();

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("resetRdy", 64'(rdy), 64'd1);
    checkOutput("resetWrens", 64'({s_wren, ct_wren}), 64'd0);
    checkOutput("resetAddrs", 64'({s_addr, pt_addr, ct_addr, ct_wrdata}), 64'd0);
    rst_n = 1'b1;

    // Identity S with a 3-byte zero plaintext.
    setIdentity();
    ptInit[0] = 8'h03;
    applyStimulus();
    waitRdy(cyc, swr);
    checkOutput("idBusyCycles", 64'(cyc), 64'd20);
    checkOutput("idSWrites", 64'(swr), 64'd6);
    checkOutput("idCt", 64'({ctMem[0], ctMem[1], ctMem[2], ctMem[3]}), 64'h03020507);
    checkOutput("idCtUntouched", 64'(ctMem[4]), 64'hAA);
    checkOutput("idS", 64'({sMem[2], sMem[3], sMem[5]}), 64'h030502);
`ifdef PRGA_CKSUM_EN
    checkOutput("idCksum", 64'(cksum), 64'h00);
`endif

    // Zero-length message.
    setIdentity();
    applyStimulus();
    waitRdy(cyc, swr);
    checkOutput("zeroBusyCycles", 64'(cyc), 64'd2);
    checkOutput("zeroSWrites", 64'(swr), 64'd0);
    checkOutput("zeroCt", 64'({ctMem[0], ctMem[1]}), 64'h00AA);

    // Round trip through a non-trivial permutation S[n] = 7n+3.
    setIdentity();
    for (int m = 0; m < 256; m++) sInit[m] = 8'(7 * m + 3);
    ptInit[0] = 8'h02;
    ptInit[1] = 8'h61;
    ptInit[2] = 8'h62;
    applyStimulus();
    waitRdy(cyc, swr);
    for (int m = 0; m < 3; m++) ptInit[m] = ctMem[m];
    for (int m = 0; m < 256; m++) ctInit[m] = 8'hAA;
    applyStimulus();
    waitRdy(cyc, swr);
    checkOutput("roundTrip", 64'({ctMem[0], ctMem[1], ctMem[2]}), 64'h026162);

    // en held high across a 1-byte run, then stray pulses mid-run.
    setIdentity();
    ptInit[0] = 8'h01;
    ptInit[1] = 8'h55;
    @(negedge clk);
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    en = 1'b1;
    @(negedge clk);
    waitRdy(cyc, swr);
    checkOutput("heldBusyCycles", 64'(cyc), 64'd8);
    @(negedge clk);
    checkOutput("heldRestart", 64'(rdy), 64'd0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    waitRdy(cyc, swr);
    checkOutput("heldSecondCt", 64'({ctMem[0], ctMem[1]}), 64'h0157);
    repeat (3) @(negedge clk);
    checkOutput("heldStaysIdle", 64'(rdy), 64'd1);

    // Reset in the WRJ cycle, then a clean restart.
    setIdentity();
    ptInit[0] = 8'h03;
    applyStimulus();
    n = 0;
    while (s_wren !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("wrjCycle", 64'(s_wren), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetRdy", 64'(rdy), 64'd1);
    checkOutput("midResetWrens", 64'({s_wren, ct_wren}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    waitRdy(cyc, swr);
    checkOutput("restartCt", 64'({ctMem[1], ctMem[2], ctMem[3]}), 64'h020507);

    // Longest message: k must reach 255 without wrapping.
    setIdentity();
    ptInit[0] = 8'hFF;
    for (int m = 1; m < 256; m++) ptInit[m] = 8'($urandom_range(0, 255));
    applyStimulus();
    waitRdy(cyc, swr);
    checkOutput("maxBusyCycles", 64'(cyc), 64'd1532);
    checkOutput("maxCtLen", 64'(ctMem[0]), 64'hFF);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
